uart_tx_ps: RTL
===============

Name: uart_tx_ps

Overview:
- Single-clock UART transmitter timed by the same `prescale` value the receiver uses, so TX and RX can share one clock domain without a dedicated TX baud clock.
- Serialises `DATA_WIDTH`-bit words as start bit, data LSB first, optional parity, and one stop bit.
- Framing controls (`par_en`, `par_typ`) match the receiver.
- Sits beside the receiver in the UART subsystem and drives the serial line.

Parameters:
DATA_WIDTH  8  payload bits per frame

Ports:
clk         input   1           system clock
rst         input   1           synchronous reset, active-high
par_en      input   1           1 = parity bit present
par_typ     input   1           0 = even parity, 1 = odd parity
prescale    input   5           clk cycles per serial bit; 0 means 32
data_valid  input   1           request to send p_data
p_data      input   DATA_WIDTH  word to transmit
busy        output  1           frame in progress; new requests ignored
tx_out      output  1           serial line, idle high

Behaviour:
- Reset: one clock, synchronous, active-high; `rst` sampled high on a rising edge.
  - Outputs after reset: `tx_out` = 1, `busy` = 0, FSM = IDLE, bit and cycle counters cleared.
  - Reset mid-frame aborts the frame. `tx_out` returns to 1 on that edge; no partial stop bit is sent.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Accept: on an edge where `busy` = 0 and `data_valid` = 1:
  - latch `p_data`, `par_en`, `par_typ` and `prescale` into internal registers;
  - after that edge, FSM = START, `busy` = 1, `tx_out` = 0.
  - Input changes during a frame have no effect.
- Requests made while `busy` = 1 are dropped, not queued. The sender must hold `data_valid` until it sees `busy` = 0.
- Bit period P = latched `prescale`, with 0 meaning 32. A 5-bit down-counter reloads at every bit boundary, and every bit is held on `tx_out` for exactly P clocks.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on accept.
  - START -> DATA after P cycles.
  - DATA shifts out bit 0 first and moves to the next bit every P cycles. After bit `DATA_WIDTH`-1 it goes to PARITY if `par_en` latched = 1, otherwise to STOP.
  - PARITY -> STOP after P cycles.
  - STOP drives 1 for P cycles, then goes to IDLE.
- Parity bit = XOR of the latched data, inverted when `par_typ` = 1.
- Frame length in bits: N = `DATA_WIDTH` + 2 + `par_en`.
  - `busy` is high for exactly N·P cycles, starting the cycle after accept.
  - `busy` falls on the same edge that STOP completes; `tx_out` is 1 at that point.
- Back-to-back frames: a `data_valid` held high is accepted on the first edge where `busy` = 0. The line is therefore idle-high for exactly 1 clk between frames, which appears as a stop bit of P+1 cycles.
- `tx_out` must not glitch: it changes only at bit boundaries, on the accept edge, or on reset.

Test Plan:
- Reset:
  - Stimulus: `rst` high for 2 cycles with `data_valid` = 1.
  - Required: `tx_out` = 1 and `busy` = 0 throughout; no frame starts until the first edge after `rst` falls.
- No parity:
  - Stimulus: `prescale` = 4, `par_en` = 0, `p_data` = 0xA5.
  - Required: `tx_out` sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 clks; `busy` high 40 cycles.
- Parity types:
  - Stimulus: `prescale` = 8, `par_en` = 1, `p_data` = 0x07.
  - Required: with `par_typ` = 0 the parity bit = 1; with `par_typ` = 1 it = 0. `busy` high 88 cycles.
- Ignored request and input changes:
  - Stimulus: during the 0xA5 frame, pulse `data_valid` with 0xFF, and change `prescale` and `par_en`.
  - Required: the frame completes unchanged as 0xA5; no second frame follows.
- Reset mid-frame and back-to-back:
  - Stimulus: assert `rst` during DATA bit 3, then hold `data_valid` = 1 with 0x3C.
  - Required: `tx_out` = 1 the cycle after `rst`. Two consecutive frames start, separated by exactly 1 idle clk.
- `prescale` = 0:
  - Stimulus: `prescale` = 0, `par_en` = 0, `p_data` = 0x01.
  - Required: each bit lasts 32 clks; `busy` high 320 cycles.

Source files
------------

// File: rtl/uart_tx_ps_if.sv
// Parallel-side bus of the prescale-timed UART transmitter: framing controls, request and line outputs.
interface uart_tx_ps_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  par_en;
  logic                  par_typ;
  logic [4:0]            prescale;
  logic                  data_valid;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  busy;
  logic                  tx_out;

  modport master (
    output par_en, par_typ, prescale, data_valid, p_data,
    input  busy, tx_out
  );

  modport slave (
    input  par_en, par_typ, prescale, data_valid, p_data,
    output busy, tx_out
  );
endinterface

// File: rtl/uart_tx_ps.sv
// UART transmitter (start, LSB-first data, optional parity, stop) timed by prescale clocks per bit.
// Latency: tx_out/busy change on the accept edge; requests while busy are dropped, not queued.
module uart_tx_ps #(
  parameter int DATA_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  uart_tx_ps_if.slave bus
);

  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_WIDTH - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]            state;
  logic [4:0]            cnt;
  logic [4:0]            presc_q;
  logic [IW-1:0]         bit_idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_en_q;
  logic                  par_bit_q;
  logic                  busy_q;
  logic                  tx_q;
  logic                  bit_done;

  assign bit_done = (cnt == 5'd0);
  assign bus.busy   = busy_q;
  assign bus.tx_out = tx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 5'd0;
      presc_q   <= 5'd0;
      bit_idx   <= '0;
      shreg     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      busy_q    <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      // Period minus one: prescale 0 wraps to 31, giving the 32-clock bit.
      if (state != IDLE) begin
        cnt <= bit_done ? (presc_q - 5'd1) : (cnt - 5'd1);
      end

      case (state)
        IDLE: begin
          if (bus.data_valid) begin
            presc_q   <= bus.prescale;
            cnt       <= bus.prescale - 5'd1;
            shreg     <= bus.p_data;
            par_en_q  <= bus.par_en;
            par_bit_q <= (^bus.p_data) ^ bus.par_typ;
            bit_idx   <= '0;
            busy_q    <= 1'b1;
            tx_q      <= 1'b0;
            state     <= START;
          end
        end
        START: begin
          if (bit_done) begin
            tx_q    <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_done) begin
            if (bit_idx == LAST_BIT) begin
              if (par_en_q) begin
                tx_q  <= par_bit_q;
                state <= PARITY;
              end else begin
                tx_q  <= 1'b1;
                state <= STOP;
              end
            end else begin
              tx_q    <= shreg[0];
              shreg   <= shreg >> 1;
              bit_idx <= bit_idx + IW'(1);
            end
          end
        end
        PARITY: begin
          if (bit_done) begin
            tx_q  <= 1'b1;
            state <= STOP;
          end
        end
        STOP: begin
          if (bit_done) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
